// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control slice: opcodes, FSM states,
// unit enable indices and default widths.
package alu_pkg;

  localparam int W_DEF   = 4;
  localparam int OPW_DEF = 3;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;

  // Bit positions inside the one-hot enable vector
  localparam int U_AND  = 0;
  localparam int U_OR   = 1;
  localparam int U_XOR  = 2;
  localparam int U_ADD  = 3;
  localparam int U_SUB  = 4;
  localparam int NUNITS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Opcode to one-hot function-unit enable decoder with illegal-opcode flag.
// Purely combinational so it can be shared by wider ALU variants.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int OPW = OPW_DEF
) (
  input  logic [OPW-1:0]    op,
  output logic [NUNITS-1:0] en,
  output logic              illegal
);

  // Map each legal opcode onto exactly one unit; anything else lights none
  always_comb begin
    en      = '0;
    illegal = 1'b0;
    case (op)
      OPW'(OP_AND): en[U_AND] = 1'b1;
      OPW'(OP_OR):  en[U_OR]  = 1'b1;
      OPW'(OP_XOR): en[U_XOR] = 1'b1;
      OPW'(OP_ADD): en[U_ADD] = 1'b1;
      OPW'(OP_SUB): en[U_SUB] = 1'b1;
      default:      illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_ctrl.sv
// Control and result stage for the 4-bit ALU function units. Accepts an
// operation, pulses one unit enable for a single cycle, captures the
// OR-combined unit result and holds it until downstream takes it.
module alu_op_ctrl
  import alu_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] Op,
  input  logic [W-1:0]   Ain,
  input  logic [W-1:0]   Bin,
  output logic [W-1:0]   A_out,
  output logic [W-1:0]   B_out,
  output logic           E_AND,
  output logic           E_OR,
  output logic           E_XOR,
  output logic           E_ADD,
  output logic           E_SUB,
  input  logic [W-1:0]   Y_in,
  input  logic           C_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   Y,
  output logic           C,
  output logic           Z,
  output logic           ERR
);

  state_t             state, state_nxt;
  logic [NUNITS-1:0]  dec_en;
  logic               dec_ill;
  logic [NUNITS-1:0]  en_p0;
  logic               ill_p0;
  logic               arith_p0;
  logic               accept;

  // Decode the incoming opcode so the enable can be registered at accept
  alu_op_decode #(.OPW(OPW)) u_decode (
    .op      (Op),
    .en      (dec_en),
    .illegal (dec_ill)
  );

  assign accept    = (state == IDLE) && in_valid;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign E_AND = en_p0[U_AND];
  assign E_OR  = en_p0[U_OR];
  assign E_XOR = en_p0[U_XOR];
  assign E_ADD = en_p0[U_ADD];
  assign E_SUB = en_p0[U_SUB];

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: EXEC always lasts one cycle, DONE waits for out_ready
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = EXEC;
      EXEC:                   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Operand/enable capture at accept, result capture at the end of EXEC.
  // The enable register is loaded at accept and cleared after EXEC, so the
  // pulse is exactly one cycle regardless of downstream backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      A_out    <= '0;
      B_out    <= '0;
      en_p0    <= '0;
      ill_p0   <= 1'b0;
      arith_p0 <= 1'b0;
      Y        <= '0;
      C        <= 1'b0;
      Z        <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      if (accept) begin
        A_out    <= Ain;
        B_out    <= Bin;
        en_p0    <= dec_en;
        ill_p0   <= dec_ill;
        arith_p0 <= dec_en[U_ADD] | dec_en[U_SUB];
      end
      if (state == EXEC) begin
        en_p0 <= '0;
        if (ill_p0) begin
          Y   <= '0;
          C   <= 1'b0;
          Z   <= 1'b1;
          ERR <= 1'b1;
        end else begin
          Y   <= Y_in;
          C   <= arith_p0 & C_in;
          Z   <= (Y_in == '0);
          ERR <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_ctrl.sv
// Directed bench for alu_op_ctrl with a behavioural model of the function units.
module tb_alu_op_ctrl;

  localparam int W   = 4;
  localparam int OPW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] Op;
  logic [W-1:0]   Ain, Bin;
  logic [W-1:0]   A_out, B_out;
  logic           E_AND, E_OR, E_XOR, E_ADD, E_SUB;
  logic [W-1:0]   Y_in;
  logic           C_in;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   Y;
  logic           C, Z, ERR;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_ctrl #(.W(W), .OPW(OPW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Op(Op), .Ain(Ain), .Bin(Bin), .A_out(A_out), .B_out(B_out),
    .E_AND(E_AND), .E_OR(E_OR), .E_XOR(E_XOR), .E_ADD(E_ADD), .E_SUB(E_SUB),
    .Y_in(Y_in), .C_in(C_in), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .C(C), .Z(Z), .ERR(ERR)
  );

  // Function units: each gated by its enable, outputs OR-combined
  logic [4:0] sum5, dif5, env;
  assign sum5 = {1'b0, A_out} + {1'b0, B_out};
  assign dif5 = {1'b0, A_out} + {1'b0, ~B_out} + 5'd1;
  assign Y_in = ({W{E_AND}} & (A_out & B_out)) | ({W{E_OR}} & (A_out | B_out)) |
                ({W{E_XOR}} & (A_out ^ B_out)) | ({W{E_ADD}} & sum5[3:0]) |
                ({W{E_SUB}} & dif5[3:0]);
  assign C_in = (E_ADD & sum5[4]) | (E_SUB & dif5[4]);
  assign env  = {E_SUB, E_ADD, E_XOR, E_OR, E_AND};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one op while IDLE, check the EXEC cycle and the DONE result
  task automatic run_op(input string tag, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [4:0] exp_en,
                        input logic [3:0] ey, input logic ec, input logic ez, input logic ee);
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1; Op = op; Ain = a; Bin = b;
    tick();
    in_valid = 1'b0;
    chk({tag, "_exec_en"}, env, exp_en);
    chk({tag, "_exec_in_ready"}, in_ready, 0);
    chk({tag, "_exec_out_valid"}, out_valid, 0);
    chk({tag, "_a_out"}, A_out, a);
    chk({tag, "_b_out"}, B_out, b);
    tick();
    chk({tag, "_done_en"}, env, 0);
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_y"}, Y, ey);
    chk({tag, "_c"}, C, ec);
    chk({tag, "_z"}, Z, ez);
    chk({tag, "_err"}, ERR, ee);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; Op = '0; Ain = '0; Bin = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_en", env, 0);
    chk("rst_ycze", {Y, C, Z, ERR}, 0);
    chk("rst_ab", {A_out, B_out}, 0);
    rst = 1'b0;
    tick();

    // AND 1100 & 1010 = 1000
    out_ready = 1'b1;
    run_op("and", 3'd0, 4'b1100, 4'b1010, 5'b00001, 4'b1000, 0, 0, 0);
    tick();
    chk("and_release_out_valid", out_valid, 0);
    chk("and_release_in_ready", in_ready, 1);
    chk("and_y_held", Y, 4'b1000);

    // Reset during EXEC discards the ADD
    in_valid = 1'b1; Op = 3'd3; Ain = 4'hF; Bin = 4'h1;
    tick();
    in_valid = 1'b0;
    chk("rstx_e_add", E_ADD, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstx_e_add_drop", E_ADD, 0);
    chk("rstx_out_valid", out_valid, 0);
    chk("rstx_in_ready", in_ready, 1);
    chk("rstx_y", Y, 0);
    tick();
    chk("rstx_out_valid_after", out_valid, 0);

    // ADD with carry: F + 1 = 0, C=1, Z=1
    run_op("add", 3'd3, 4'hF, 4'h1, 5'b01000, 4'h0, 1, 1, 0);
    tick();

    // Illegal opcode
    run_op("ill", 3'd6, 4'h5, 4'h3, 5'b00000, 4'h0, 0, 1, 1);
    tick();

    // Backpressure: XOR 9 ^ 3 = A held for 5 cycles
    out_ready = 1'b0;
    run_op("xor", 3'd2, 4'h9, 4'h3, 5'b00100, 4'hA, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin in_valid = 1'b1; Op = 3'd0; Ain = 4'hF; Bin = 4'hF; end
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_y", Y, 4'hA);
      chk("bp_en", env, 0);
    end
    in_valid = 1'b0;
    chk("bp_a_out_kept", A_out, 4'h9);
    out_ready = 1'b1;
    tick();
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);

    // Back-to-back with in_valid and out_ready held high: accepts every 3 cycles
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [2:0] op; logic [3:0] a, b, ey; logic [4:0] een; logic ec, ez;
      case (k)
        0: begin op = 3'd1; a = 4'h3; b = 4'h4; een = 5'b00010; ey = 4'h7; ec = 0; ez = 0; end
        1: begin op = 3'd4; a = 4'h5; b = 4'h3; een = 5'b10000; ey = 4'h2; ec = 1; ez = 0; end
        default: begin op = 3'd4; a = 4'h3; b = 4'h5; een = 5'b10000; ey = 4'hE; ec = 0; ez = 0; end
      endcase
      chk("b2b_accept_slot", in_ready, 1);
      Op = op; Ain = a; Bin = b;
      tick();
      chk("b2b_en", env, een);
      tick();
      chk("b2b_out_valid", out_valid, 1);
      chk("b2b_y", Y, ey);
      chk("b2b_c", C, ec);
      chk("b2b_z", Z, ez);
      chk("b2b_in_ready_done", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_final_in_ready", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
